sqrt_arbiter: RTL and testbench

- Shares one half-precision square-root unit between N_REQ requesters using round-robin arbitration.
- For each granted request it sequences the unit's ENABLE and its bidirectional 16-bit data bus: drive the operand, release the bus, wait for RESULT, capture the result and flags.
- It then returns the captured result to the granted requester and forces a low-ENABLE gap so the unit clears before the next operation.
- Sits between the requester fabric and the sqrt unit; it is the only master of the unit's ENABLE and bus.

---
 rtl/sqrt_arbiter.sv | 131 +++++++++++++
 tb/tb_sqrt_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter that time-shares one half-precision square-root unit.
// It sequences the unit's enable/bus handshake and returns each result to its requester.
module sqrt_arbiter #(
  parameter int N_REQ       = 4,
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 64,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [N_REQ-1:0]     REQ_VALID,
  input  logic [16*N_REQ-1:0]  REQ_DATA,
  output logic [N_REQ-1:0]     REQ_READY,
  output logic [N_REQ-1:0]     RSP_VALID,
  output logic [15:0]          RSP_DATA,
  output logic [3:0]           RSP_FLAGS,
  output logic                 BUSY,
  inout  logic [15:0]          SQ_DATA,
  output logic                 SQ_ENABLE,
  input  logic                 SQ_RESULT,
  input  logic                 SQ_IS_NAN,
  input  logic                 SQ_IS_PINF,
  input  logic                 SQ_IS_NINF
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + LOAD_CYCLES + GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   grant;
  logic [PW-1:0]   grant_n;
  logic [PW-1:0]   idx;
  logic            found;
  logic            hs;
  logic [15:0]     operand;
  logic [CW-1:0]   cnt;
  logic            drive;
  logic            sq_en;
  logic            timed_out;

  // Search upward from the pointer, wrapping, for the first valid requester.
  always_comb begin
    found   = 1'b0;
    grant_n = '0;
    idx     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = PW'((32'(ptr) + i) % 32'(N_REQ));
      if (!found && REQ_VALID[idx]) begin
        found   = 1'b1;
        grant_n = idx;
      end
    end
  end

  always_comb begin
    REQ_READY = '0;
    if (state == S_IDLE && found) begin
      REQ_READY[grant_n] = 1'b1;
    end
  end

  assign hs        = |(REQ_VALID & REQ_READY);
  assign timed_out = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (hs) state_n = S_LOAD;
      S_LOAD: if (cnt == CW'(LOAD_CYCLES - 1)) state_n = S_WAIT;
      S_WAIT: if (SQ_RESULT || timed_out) state_n = S_RESP;
      S_RESP: state_n = S_GAP;
      S_GAP:  if (cnt == CW'(GAP_CYCLES - 1)) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      ptr       <= '0;
      grant     <= '0;
      operand   <= '0;
      cnt       <= '0;
      drive     <= 1'b0;
      sq_en     <= 1'b0;
      RSP_DATA  <= '0;
      RSP_FLAGS <= '0;
    end else begin
      state <= state_n;
      // Bus driver and enable are registered from the next state so they never glitch.
      drive <= (state_n == S_LOAD);
      sq_en <= (state_n == S_LOAD) || (state_n == S_WAIT);
      cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
      if (state == S_IDLE && hs) begin
        operand <= REQ_DATA[16*grant_n +: 16];
        grant   <= grant_n;
        ptr     <= (grant_n == PW'(N_REQ - 1)) ? '0 : grant_n + 1'b1;
      end
      if (state == S_WAIT) begin
        if (SQ_RESULT) begin
          RSP_DATA  <= SQ_DATA;
          RSP_FLAGS <= {1'b0, SQ_IS_NINF, SQ_IS_PINF, SQ_IS_NAN};
        end else if (timed_out) begin
          RSP_DATA  <= 16'hFE00;
          RSP_FLAGS <= 4'b1001;
        end
      end
    end
  end

  always_comb begin
    RSP_VALID = '0;
    if (state == S_RESP) begin
      RSP_VALID[grant] = 1'b1;
    end
  end

  assign BUSY      = (state != S_IDLE);
  assign SQ_ENABLE = sq_en;
  assign SQ_DATA   = drive ? operand : 'z;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: behavioural sqrt unit, scoreboard of expected responses,
// and directed sequences for gap clearing, timeout, mid-operation reset and fairness.
module tb_sqrt_arbiter;

  localparam int N_REQ       = 4;
  localparam int LOAD_CYCLES = 2;
  localparam int TIMEOUT     = 64;
  localparam int GAP_CYCLES  = 2;
  localparam int UNIT_LAT    = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [16*N_REQ-1:0] req_data = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [15:0]         rsp_data;
  logic [3:0]          rsp_flags;
  logic                busy;
  wire  [15:0]         sq_data;
  logic                sq_enable;
  logic                u_res = 1'b0;
  logic                u_nan = 1'b0;
  logic                u_pinf = 1'b0;
  logic                u_ninf = 1'b0;

  typedef struct {
    int unsigned req;
    logic [15:0] data;
    logic [3:0]  flags;
  } exp_t;

  exp_t        sb[$];
  int unsigned grant_log[$];
  int          errs = 0;
  int          checks = 0;
  logic        stub_mode = 1'b0;
  logic [15:0] last_op = '0;

  // Behavioural unit state
  int          ucnt = 0;
  logic        u_drive = 1'b0;
  logic [15:0] u_val = '0;
  logic [15:0] u_op = '0;

  sqrt_arbiter #(
    .N_REQ(N_REQ),
    .LOAD_CYCLES(LOAD_CYCLES),
    .TIMEOUT(TIMEOUT),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .REQ_VALID(req_valid),
    .REQ_DATA(req_data),
    .REQ_READY(req_ready),
    .RSP_VALID(rsp_valid),
    .RSP_DATA(rsp_data),
    .RSP_FLAGS(rsp_flags),
    .BUSY(busy),
    .SQ_DATA(sq_data),
    .SQ_ENABLE(sq_enable),
    .SQ_RESULT(u_res),
    .SQ_IS_NAN(u_nan),
    .SQ_IS_PINF(u_pinf),
    .SQ_IS_NINF(u_ninf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {ninf, pinf, nan, result} for the operands this bench uses
  function automatic logic [18:0] sqrt_ref(input logic [15:0] x);
    case (x)
      16'h4400: return {3'b000, 16'h4000};
      16'h3C00: return {3'b000, 16'h3C00};
      16'h4C00: return {3'b000, 16'h4400};
      16'h5400: return {3'b000, 16'h4800};
      16'h7C00: return {3'b010, 16'h7C00};
      16'h0000: return {3'b000, 16'h0000};
      default:  return (x[15] && x[14:0] != 15'd0) ? {3'b001, 16'hFE00} : {3'b000, 16'h0000};
    endcase
  endfunction

  // Unit model: samples the operand on its first enabled edge, answers UNIT_LAT
  // edges after the load window, holds the answer until enable drops.
  always @(posedge clk) begin
    if (!sq_enable) begin
      ucnt    <= 0;
      u_drive <= 1'b0;
      u_res   <= 1'b0;
      u_nan   <= 1'b0;
      u_pinf  <= 1'b0;
      u_ninf  <= 1'b0;
    end else begin
      ucnt <= ucnt + 1;
      if (ucnt == 0) u_op <= sq_data;
      if (!stub_mode && ucnt == LOAD_CYCLES + UNIT_LAT - 1) begin
        u_drive <= 1'b1;
        u_res   <= 1'b1;
        {u_ninf, u_pinf, u_nan, u_val} <= sqrt_ref(u_op);
      end
    end
  end

  assign sq_data = u_drive ? u_val : 'z;

  // Handshake monitor: the handshake seen here completes on the next rising edge.
  always @(negedge clk) begin : hs_mon
    int unsigned g;
    logic [15:0] op;
    logic [18:0] r;
    exp_t        e;
    if (rst_n && |(req_valid & req_ready)) begin
      g = 0;
      for (int unsigned i = 0; i < N_REQ; i++)
        if (req_valid[i] && req_ready[i]) g = i;
      op = req_data[g*16 +: 16];
      e.req = g;
      if (stub_mode) begin
        e.data  = 16'hFE00;
        e.flags = 4'b1001;
      end else begin
        r       = sqrt_ref(op);
        e.data  = r[15:0];
        e.flags = {1'b0, r[18:16]};
      end
      sb.push_back(e);
      grant_log.push_back(g);
      last_op = op;
    end
  end

  always @(negedge clk) begin : rsp_mon
    exp_t e;
    if (rst_n) begin
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (busy) check("ready_when_busy", 32'(req_ready), 32'd0);
      if (|rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_grant", 32'(rsp_valid), 32'd1 << e.req);
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
        end
      end
      if (sq_enable && ucnt < LOAD_CYCLES) check("bus_load", 32'(sq_data), 32'(last_op));
      if (u_drive) check("bus_unit", 32'(sq_data), 32'(u_val));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int unsigned idx, input logic [15:0] op);
    req_data[idx*16 +: 16] = op;
    req_valid[idx] = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        tick();
        req_valid[idx] = 1'b0;
        return;
      end
    end
    check("grant_timeout", 32'd0, 32'd1);
    req_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) return;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic rsp_then_gap();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (|rsp_valid) break;
    end
    check("rsp_seen", 32'(n < 200), 32'd1);
    for (int k = 0; k < GAP_CYCLES; k++) begin
      @(negedge clk);
      check("gap_enable", 32'(sq_enable), 32'd0);
      check("gap_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("idle_after_gap", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int n;
    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_enable", 32'(sq_enable), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request and the enable gap after it
    send(1, 16'h4400);
    rsp_then_gap();

    // Negative operand yields NaN; the following operand must be unaffected
    send(0, 16'hBC00);
    drain();
    send(0, 16'h3C00);
    drain();
    send(2, 16'h7C00);
    drain();

    // Unit never answers: timeout after exactly TIMEOUT wait cycles
    stub_mode = 1'b1;
    send(3, 16'h4400);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sq_enable) n++;
      else break;
    end
    check("timeout_enable_cycles", 32'(n), 32'(LOAD_CYCLES + TIMEOUT));
    drain();
    stub_mode = 1'b0;
    send(3, 16'h5400);
    drain();

    // Reset in the third wait cycle aborts silently and clears the pointer
    stub_mode = 1'b1;
    send(2, 16'h4C00);
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ucnt == LOAD_CYCLES + 2) break;
    end
    check("reach_wait3", 32'(n < 100), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_enable", 32'(sq_enable), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    stub_mode = 1'b0;
    rst_n = 1'b1;
    req_data[2*16 +: 16] = 16'h4C00;
    req_data[3*16 +: 16] = 16'h3C00;
    req_valid[2] = 1'b1;
    req_valid[3] = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'h4);
    tick();
    req_valid[2] = 1'b0;
    send(3, 16'h3C00);
    drain();

    // Fairness with all requesters continuously valid
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    grant_log.delete();
    req_data = {16'h5400, 16'h4C00, 16'h3C00, 16'h4400};
    req_valid = '1;
    for (n = 0; n < 2000; n++) begin
      @(posedge clk);
      if (grant_log.size() >= 8) break;
    end
    #1;
    req_valid = '0;
    check("fair_grants", 32'(grant_log.size()), 32'd8);
    drain();
    for (int i = 0; i < 8; i++) begin
      if (i < grant_log.size()) check("grant_order", 32'(grant_log[i]), 32'(i % N_REQ));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
